// File: rtl/ram.sv
// Single-port synchronous RAM: one shared address, registered read data with
// write-through on read-during-write, and a synchronous reset that clears only q.
module ram #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q
);

    // The array has no reset; it relies on the device's zero-initialised
    // power-up contents and is deliberately preserved across reset_n.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic wr_en;
    assign wr_en = reset_n && wren;

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[address] <= data;
    end

    // Write-through: a write edge returns the new word rather than the stale one.
    always_ff @(posedge clock) begin
        if (!reset_n)
            q <= '0;
        else if (wren)
            q <= data;
        else
            q <= mem[address];
    end

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for ram: each step drives inputs, clocks one
// rising edge and checks q against a hand-computed value.
module tb_ram;

    localparam int AW = 11;
    localparam int DW = 16;

    logic          clock;
    logic          reset_n;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic          wren;
    logic [DW-1:0] q;

    int total = 0;
    int bad   = 0;

    ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [DW-1:0] exp);
        total++;
        assert (q === exp) else begin
            bad++;
            $error("FAIL %s: q=%h expected=%h", tag, q, exp);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic rst_n, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        reset_n = rst_n;
        wren    = we;
        address = a;
        data    = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        wren    = 1'b0;
        address = '0;
        data    = '0;

        // reset state
        step(1'b0, 1'b0, 11'h000, 16'h0000);
        step(1'b0, 1'b0, 11'h000, 16'h0000);
        chk("reset_q", 16'h0000);

        // power-up contents
        step(1'b1, 1'b0, 11'h200, 16'hFFFF);
        chk("powerup_200", 16'h0000);

        // back-to-back writes, each returning write-through data
        step(1'b1, 1'b1, 11'h001, 16'hABCD); chk("wr_001", 16'hABCD);
        step(1'b1, 1'b1, 11'h002, 16'h1234); chk("wr_002", 16'h1234);
        step(1'b1, 1'b1, 11'h003, 16'h5678); chk("wr_003", 16'h5678);
        step(1'b1, 1'b0, 11'h001, 16'h9999); chk("rd_001", 16'hABCD);
        step(1'b1, 1'b0, 11'h002, 16'h9999); chk("rd_002", 16'h1234);
        step(1'b1, 1'b0, 11'h003, 16'h9999); chk("rd_003", 16'h5678);

        // q holds between edges despite address moving
        address = 11'h001;
        #2;
        chk("hold_q", 16'h5678);

        // read-during-write
        step(1'b1, 1'b1, 11'h010, 16'hBEEF); chk("rdw_010", 16'hBEEF);
        step(1'b1, 1'b0, 11'h010, 16'h0000); chk("rd_010", 16'hBEEF);

        // reset suppresses writes and clears only q
        step(1'b1, 1'b1, 11'h005, 16'h00FF); chk("wr_005", 16'h00FF);
        step(1'b0, 1'b1, 11'h005, 16'h1111); chk("rst1_q", 16'h0000);
        step(1'b0, 1'b1, 11'h005, 16'h1111); chk("rst2_q", 16'h0000);
        step(1'b1, 1'b0, 11'h005, 16'h0000); chk("rd_005", 16'h00FF);

        // reset during a write burst drops only the reset-edge write
        step(1'b1, 1'b1, 11'h020, 16'h0001);
        step(1'b1, 1'b1, 11'h021, 16'h0002);
        step(1'b0, 1'b1, 11'h022, 16'h0003); chk("burst_rst_q", 16'h0000);
        step(1'b1, 1'b0, 11'h020, 16'h0000); chk("burst_020", 16'h0001);
        step(1'b1, 1'b0, 11'h021, 16'h0000); chk("burst_021", 16'h0002);
        step(1'b1, 1'b0, 11'h022, 16'h0000); chk("burst_022", 16'h0000);

        // boundary addresses
        step(1'b1, 1'b1, 11'h000, 16'hAAAA);
        step(1'b1, 1'b1, 11'h7FF, 16'h5555);
        step(1'b1, 1'b0, 11'h000, 16'h0000); chk("rd_000", 16'hAAAA);
        step(1'b1, 1'b0, 11'h7FF, 16'h0000); chk("rd_7ff", 16'h5555);

        // overwrite
        step(1'b1, 1'b1, 11'h100, 16'h1234);
        step(1'b1, 1'b1, 11'h100, 16'h4321);
        step(1'b1, 1'b0, 11'h100, 16'h0000); chk("rd_100", 16'h4321);

        // unknown address with wren=0 leaves contents intact
        step(1'b1, 1'b0, 11'bx, 16'hDEAD);
        step(1'b1, 1'b0, 11'h001, 16'h0000); chk("x_addr_001", 16'hABCD);
        step(1'b1, 1'b0, 11'h000, 16'h0000); chk("x_addr_000", 16'hAAAA);
        step(1'b1, 1'b0, 11'h200, 16'h0000); chk("rd_200", 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
